// File: rtl/ace_wr_arb_pkg.sv
// Shared types and constants for the ACE write-port arbiter.
package ace_wr_arb_pkg;

   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_ADDR = 3'd1,
      ST_DATA = 3'd2,
      ST_RESP = 3'd3,
      ST_ACK  = 3'd4
   } state_t;

   typedef enum logic [1:0] {
      BRESP_OKAY   = 2'b00,
      BRESP_EXOKAY = 2'b01,
      BRESP_SLVERR = 2'b10,
      BRESP_DECERR = 2'b11
   } bresp_t;

   localparam logic [1:0] AWBURST_INCR = 2'b01;
   localparam logic [3:0] AWCACHE_DEF  = 4'b0010;

   function automatic logic [2:0] awsize_of(input int data_w);
      return 3'($clog2(data_w / 8));
   endfunction

endpackage

// File: rtl/ace_wr_arbiter_rr_arbiter.sv
// Combinational round-robin picker: first request at or after last+1 (mod NREQ).
module rr_arbiter #(
   parameter int NREQ  = 2,
   parameter int IDX_W = 1
) (
   input  logic [NREQ-1:0]  i_req,
   input  logic [IDX_W-1:0] i_last,
   output logic [NREQ-1:0]  o_grant,
   output logic [IDX_W-1:0] o_idx,
   output logic             o_any
);

   logic [IDX_W-1:0] w_cand;
   logic             w_hit;

   // Walk the ring starting after the previous winner; the first hit wins.
   always_comb begin
      o_grant = '0;
      o_idx   = '0;
      o_any   = 1'b0;
      w_cand  = '0;
      w_hit   = 1'b0;
      for (int k = 1; k <= NREQ; k++) begin
         w_cand          = IDX_W'((int'(i_last) + k) % NREQ);
         w_hit           = i_req[w_cand] & ~o_any;
         o_grant[w_cand] = o_grant[w_cand] | w_hit;
         o_idx           = w_hit ? w_cand : o_idx;
         o_any           = o_any | w_hit;
      end
   end

endmodule

// File: rtl/ace_wr_arbiter.sv
// Shares one ACE write master port between NREQ requesters, one transaction at a time,
// round-robin grant, B response returned to the owner together with the WACK pulse.
module ace_wr_arbiter
   import ace_wr_arb_pkg::*;
#(
   parameter int NREQ   = 2,
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32,
   parameter int ID_W   = 4
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [NREQ-1:0]          req_valid,
   output logic [NREQ-1:0]          req_ready,
   input  logic [NREQ*ADDR_W-1:0]   req_addr,
   input  logic [NREQ*8-1:0]        req_len,
   input  logic [NREQ*ID_W-1:0]     req_id,
   input  logic [NREQ*3-1:0]        req_snoop,
   input  logic [NREQ*2-1:0]        req_domain,
   input  logic [NREQ*DATA_W-1:0]   req_wdata,
   input  logic [NREQ*DATA_W/8-1:0] req_wstrb,
   input  logic [NREQ-1:0]          req_wvalid,
   output logic [NREQ-1:0]          req_wready,
   output logic [NREQ-1:0]          rsp_valid,
   output logic [1:0]               rsp_resp,
   output logic                     id_err,
   output logic [ADDR_W-1:0]        awaddr,
   output logic [ID_W-1:0]          awid,
   output logic [7:0]               awlen,
   output logic [2:0]               awsize,
   output logic [1:0]               awburst,
   output logic [3:0]               awcache,
   output logic [2:0]               awprot,
   output logic                     awlock,
   output logic [2:0]               awsnoop,
   output logic [1:0]               awdomain,
   output logic [1:0]               awbar,
   output logic                     awunique,
   output logic                     awvalid,
   input  logic                     awready,
   output logic [DATA_W-1:0]        wdata,
   output logic [DATA_W/8-1:0]      wstrb,
   output logic                     wlast,
   output logic                     wvalid,
   input  logic                     wready,
   input  logic [ID_W-1:0]          bid,
   input  logic [1:0]               bresp,
   input  logic                     bvalid,
   output logic                     bready,
   output logic                     wack
);

   localparam int IDX_W  = (NREQ > 1) ? $clog2(NREQ) : 1;
   localparam int STRB_W = DATA_W / 8;

   state_t             r_state, w_next;
   logic [IDX_W-1:0]   r_last;
   logic [ADDR_W-1:0]  r_addr;
   logic [7:0]         r_len, r_cnt;
   logic [ID_W-1:0]    r_id;
   logic [2:0]         r_snoop;
   logic [1:0]         r_domain, r_resp;
   logic               r_id_err;
   logic [NREQ-1:0]    w_arb_grant;
   logic [IDX_W-1:0]   w_arb_idx;
   logic               w_arb_any, w_in_addr, w_in_data, w_beat;

   rr_arbiter #(.NREQ(NREQ), .IDX_W(IDX_W)) u_rr (
      .i_req   (req_valid),
      .i_last  (r_last),
      .o_grant (w_arb_grant),
      .o_idx   (w_arb_idx),
      .o_any   (w_arb_any)
   );

   assign w_in_addr = (r_state == ST_ADDR);
   assign w_in_data = (r_state == ST_DATA);
   assign w_beat    = w_in_data & req_wvalid[r_last] & wready;

   // Next-state decode; the beat with the counter at zero is the last one.
   always_comb begin
      w_next = r_state;
      case (r_state)
         ST_IDLE: w_next = w_arb_any ? ST_ADDR : ST_IDLE;
         ST_ADDR: w_next = awready ? ST_DATA : ST_ADDR;
         ST_DATA: w_next = (w_beat && r_cnt == 8'd0) ? ST_RESP : ST_DATA;
         ST_RESP: w_next = bvalid ? ST_ACK : ST_RESP;
         ST_ACK:  w_next = ST_IDLE;
         default: w_next = ST_IDLE;
      endcase
   end

   // State, captured command, beat counter, response and sticky ID error.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state  <= ST_IDLE;
         r_last   <= IDX_W'(NREQ - 1);
         r_addr   <= '0;
         r_len    <= 8'd0;
         r_cnt    <= 8'd0;
         r_id     <= '0;
         r_snoop  <= 3'd0;
         r_domain <= 2'd0;
         r_resp   <= BRESP_OKAY;
         r_id_err <= 1'b0;
      end else begin
         r_state <= w_next;
         if (r_state == ST_IDLE && w_arb_any) begin
            r_last   <= w_arb_idx;
            r_addr   <= req_addr[w_arb_idx*ADDR_W +: ADDR_W];
            r_len    <= req_len[w_arb_idx*8 +: 8];
            r_id     <= req_id[w_arb_idx*ID_W +: ID_W];
            r_snoop  <= req_snoop[w_arb_idx*3 +: 3];
            r_domain <= req_domain[w_arb_idx*2 +: 2];
         end
         if (w_in_addr && awready) begin
            r_cnt <= r_len;
         end else if (w_beat && r_cnt != 8'd0) begin
            r_cnt <= r_cnt - 8'd1;
         end
         if (r_state == ST_RESP && bvalid) begin
            r_resp <= bresp;
            if (bid != r_id) begin
               r_id_err <= 1'b1;
            end
         end
      end
   end

   // Requester-side handshakes; only the owner ever sees a ready.
   always_comb begin
      req_ready  = '0;
      req_wready = '0;
      rsp_valid  = '0;
      if (r_state == ST_IDLE && !rst) begin
         req_ready = w_arb_grant;
      end else begin
         req_ready = '0;
      end
      if (w_in_data) begin
         req_wready[r_last] = wready;
      end else begin
         req_wready = '0;
      end
      if (r_state == ST_ACK) begin
         rsp_valid[r_last] = 1'b1;
      end else begin
         rsp_valid = '0;
      end
   end

   assign awvalid  = w_in_addr;
   assign awaddr   = w_in_addr ? r_addr : '0;
   assign awid     = w_in_addr ? r_id : '0;
   assign awlen    = w_in_addr ? r_len : 8'd0;
   assign awsize   = w_in_addr ? awsize_of(DATA_W) : 3'd0;
   assign awburst  = w_in_addr ? AWBURST_INCR : 2'b00;
   assign awcache  = w_in_addr ? AWCACHE_DEF : 4'b0000;
   assign awprot   = 3'b000;
   assign awlock   = 1'b0;
   assign awsnoop  = w_in_addr ? r_snoop : 3'd0;
   assign awdomain = w_in_addr ? r_domain : 2'd0;
   assign awbar    = 2'b00;
   assign awunique = 1'b0;

   assign wvalid = w_in_data & req_wvalid[r_last];
   assign wdata  = w_in_data ? req_wdata[r_last*DATA_W +: DATA_W] : '0;
   assign wstrb  = w_in_data ? req_wstrb[r_last*STRB_W +: STRB_W] : '0;
   assign wlast  = w_in_data & (r_cnt == 8'd0);

   assign bready   = (r_state == ST_RESP);
   assign wack     = (r_state == ST_ACK);
   assign rsp_resp = wack ? r_resp : 2'b00;
   assign id_err   = r_id_err;

endmodule

// File: tb/tb_ace_wr_arbiter.sv
// Randomised and directed bench for ace_wr_arbiter against a transaction-level model.
module tb_ace_wr_arbiter;

   localparam int NREQ = 2, ADDR_W = 32, DATA_W = 32, ID_W = 4, STRB_W = 4;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic [NREQ-1:0] req_valid = '0, req_ready, req_wvalid = '0, req_wready, rsp_valid;
   logic [NREQ*ADDR_W-1:0] req_addr = '0;
   logic [NREQ*8-1:0] req_len = '0;
   logic [NREQ*ID_W-1:0] req_id = '0;
   logic [NREQ*3-1:0] req_snoop = '0;
   logic [NREQ*2-1:0] req_domain = '0;
   logic [NREQ*DATA_W-1:0] req_wdata = '0;
   logic [NREQ*STRB_W-1:0] req_wstrb = '0;
   logic [1:0] rsp_resp;
   logic id_err;
   logic [ADDR_W-1:0] awaddr;
   logic [ID_W-1:0] awid;
   logic [7:0] awlen;
   logic [2:0] awsize, awprot, awsnoop;
   logic [1:0] awburst, awdomain, awbar;
   logic [3:0] awcache;
   logic awlock, awunique, awvalid;
   logic awready = 1'b0;
   logic [DATA_W-1:0] wdata;
   logic [STRB_W-1:0] wstrb;
   logic wlast, wvalid;
   logic wready = 1'b0;
   logic [ID_W-1:0] bid = '0;
   logic [1:0] bresp = 2'b00;
   logic bvalid = 1'b0;
   logic bready, wack;

   ace_wr_arbiter #(.NREQ(NREQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .ID_W(ID_W)) dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr), .req_len(req_len),
      .req_id(req_id), .req_snoop(req_snoop), .req_domain(req_domain),
      .req_wdata(req_wdata), .req_wstrb(req_wstrb), .req_wvalid(req_wvalid), .req_wready(req_wready),
      .rsp_valid(rsp_valid), .rsp_resp(rsp_resp), .id_err(id_err),
      .awaddr(awaddr), .awid(awid), .awlen(awlen), .awsize(awsize), .awburst(awburst),
      .awcache(awcache), .awprot(awprot), .awlock(awlock), .awsnoop(awsnoop), .awdomain(awdomain),
      .awbar(awbar), .awunique(awunique), .awvalid(awvalid), .awready(awready),
      .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
      .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready), .wack(wack)
   );

   always #5 clk = ~clk;

   int n_cmp = 0, n_err = 0, cyc = 0;

   // transaction-level model
   bit m_act = 0, m_aw_done = 0, m_b_done = 0, m_iderr = 0;
   int m_g = 0, m_last = NREQ - 1, m_left = 0;
   logic [ADDR_W-1:0] m_addr = '0;
   logic [7:0] m_len = '0;
   logic [ID_W-1:0] m_id = '0;
   logic [2:0] m_snoop = '0;
   logic [1:0] m_dom = '0, m_resp = '0;

   // stimulus knobs
   int aw_delay = 0, aw_cnt = 0, aw_pct = 100, w_mode = 0, w_pct = 100, wv_pct = 100, b_pct = 100;
   int bid_force = -1, bresp_force = 0;
   bit drop_on_grant = 1, rand_req = 0, w_tog = 0;
   logic [NREQ-1:0] prev_ready = '0;

   // observation traces
   int grants[$];
   int n_awv, n_beats, n_wlast, wlast_at, n_wack, t_ready, t_ack, n_bad_wr;
   logic [NREQ-1:0] ack_rspv;
   logic [1:0] ack_resp;
   logic ack_ie;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   function automatic int rr_pick();
      for (int k = 1; k <= NREQ; k++) begin
         int j = (m_last + k) % NREQ;
         if (req_valid[j]) return j;
      end
      return -1;
   endfunction

   task automatic clear_traces();
      grants.delete();
      n_awv = 0; n_beats = 0; n_wlast = 0; wlast_at = 0; n_wack = 0;
      t_ready = -1; t_ack = -1; n_bad_wr = 0;
      ack_rspv = '0; ack_resp = '0; ack_ie = 1'b0;
   endtask

   task automatic set_cmd(input int i, input logic [31:0] a, input logic [7:0] l, input logic [3:0] id);
      req_valid[i] = 1'b1;
      req_addr[i*ADDR_W +: ADDR_W] = a;
      req_len[i*8 +: 8] = l;
      req_id[i*ID_W +: ID_W] = id;
      req_snoop[i*3 +: 3] = 3'($urandom_range(0, 7));
      req_domain[i*2 +: 2] = 2'($urandom_range(0, 3));
   endtask

   task automatic tick();
      @(negedge clk);
      if (drop_on_grant) req_valid = req_valid & ~prev_ready;
      for (int i = 0; i < NREQ; i++) begin
         if (rand_req && !req_valid[i] && $urandom_range(0, 99) < 30)
            set_cmd(i, $urandom, 8'($urandom_range(0, 7)), 4'($urandom_range(0, 15)));
         req_wvalid[i] = ($urandom_range(0, 99) < wv_pct);
         req_wdata[i*DATA_W +: DATA_W] = $urandom;
         req_wstrb[i*STRB_W +: STRB_W] = 4'($urandom_range(0, 15));
      end
      if (aw_delay >= 0) begin
         awready = awvalid && (aw_cnt >= aw_delay);
         aw_cnt = awvalid ? aw_cnt + 1 : 0;
      end else begin
         awready = ($urandom_range(0, 99) < aw_pct);
      end
      if (w_mode == 1) begin
         w_tog = ~w_tog;
         wready = w_tog;
      end else begin
         wready = ($urandom_range(0, 99) < w_pct);
      end
      bvalid = ($urandom_range(0, 99) < b_pct);
      bresp = (bresp_force >= 0) ? 2'(bresp_force) : 2'($urandom_range(0, 3));
      if (bid_force >= 0) bid = ID_W'(bid_force);
      else if (bid_force == -2 && $urandom_range(0, 99) < 15) bid = 4'($urandom_range(0, 15));
      else bid = m_id;
   endtask

   task automatic eval();
      logic [NREQ-1:0] e_rdy, e_wrdy, e_rspv;
      logic [1:0] e_resp;
      logic e_ie, e_awv, e_wv, e_wl, e_br, e_wack;
      logic [ADDR_W-1:0] e_awaddr;
      logic [ID_W-1:0] e_awid;
      logic [7:0] e_awlen;
      logic [2:0] e_awsize;
      logic [17:0] e_attr;
      logic [DATA_W-1:0] e_wdata;
      logic [STRB_W-1:0] e_wstrb;
      int g;
      #1;
      cyc++;
      e_rdy = '0; e_wrdy = '0; e_rspv = '0; e_resp = '0; e_awv = 0; e_wv = 0; e_wl = 0;
      e_br = 0; e_wack = 0; e_awaddr = '0; e_awid = '0; e_awlen = '0; e_awsize = '0;
      e_attr = '0; e_wdata = '0; e_wstrb = '0; g = -1;
      if (!rst) begin
         if (!m_act) begin
            g = rr_pick();
            if (g >= 0) e_rdy[g] = 1'b1;
         end else if (!m_aw_done) begin
            e_awv = 1; e_awaddr = m_addr; e_awid = m_id; e_awlen = m_len; e_awsize = 3'd2;
            e_attr = {2'b01, 4'b0010, 3'b000, 1'b0, m_snoop, m_dom, 2'b00, 1'b0};
         end else if (m_left > 0) begin
            e_wv = req_wvalid[m_g];
            e_wdata = req_wdata[m_g*DATA_W +: DATA_W];
            e_wstrb = req_wstrb[m_g*STRB_W +: STRB_W];
            e_wl = (m_left == 1);
            e_wrdy[m_g] = wready;
         end else if (!m_b_done) begin
            e_br = 1;
         end else begin
            e_wack = 1; e_rspv[m_g] = 1'b1; e_resp = m_resp;
         end
      end
      e_ie = rst ? 1'b0 : m_iderr;

      chk("req_ready", req_ready, e_rdy);
      chk("req_wready", req_wready, e_wrdy);
      chk("rsp_valid", rsp_valid, e_rspv);
      chk("rsp_resp", rsp_resp, e_resp);
      chk("id_err", id_err, e_ie);
      chk("awvalid", awvalid, e_awv);
      chk("awaddr", awaddr, e_awaddr);
      chk("awid", awid, e_awid);
      chk("awlen", awlen, e_awlen);
      chk("awsize", awsize, e_awsize);
      chk("aw_attr", {awburst, awcache, awprot, awlock, awsnoop, awdomain, awbar, awunique}, e_attr);
      chk("wvalid", wvalid, e_wv);
      chk("wlast", wlast, e_wl);
      chk("wdata", wdata, e_wdata);
      chk("wstrb", wstrb, e_wstrb);
      chk("bready", bready, e_br);
      chk("wack", wack, e_wack);

      for (int i = 0; i < NREQ; i++) if (req_ready[i]) begin
         grants.push_back(i);
         if (t_ready < 0) t_ready = cyc;
      end
      if (awvalid) n_awv++;
      if (wvalid && wready) begin
         n_beats++;
         if (wlast) begin n_wlast++; wlast_at = n_beats; end
      end
      if (wack) begin
         n_wack++;
         if (t_ack < 0) t_ack = cyc;
         ack_rspv = rsp_valid; ack_resp = rsp_resp; ack_ie = id_err;
      end
      if ($countones(req_wready) > 1) n_bad_wr++;
      prev_ready = req_ready;

      if (rst) begin
         m_act = 0; m_last = NREQ - 1; m_iderr = 0;
      end else if (!m_act) begin
         if (g >= 0) begin
            m_act = 1; m_g = g; m_last = g;
            m_addr = req_addr[g*ADDR_W +: ADDR_W]; m_len = req_len[g*8 +: 8];
            m_id = req_id[g*ID_W +: ID_W]; m_snoop = req_snoop[g*3 +: 3]; m_dom = req_domain[g*2 +: 2];
            m_aw_done = 0; m_left = int'(m_len) + 1; m_b_done = 0;
         end
      end else if (!m_aw_done) begin
         if (awready) m_aw_done = 1;
      end else if (m_left > 0) begin
         if (req_wvalid[m_g] && wready) m_left--;
      end else if (!m_b_done) begin
         if (bvalid) begin
            m_b_done = 1; m_resp = bresp;
            if (bid !== m_id) m_iderr = 1;
         end
      end else begin
         m_act = 0;
      end
   endtask

   task automatic step();
      tick();
      eval();
   endtask

   task automatic do_reset();
      tick(); rst = 1'b1; req_valid = '0; eval();
      step();
      tick(); rst = 1'b0; eval();
   endtask

   task automatic run_until_wack(input int n, input int limit, input string name);
      int k = 0;
      while (n_wack < n && k < limit) begin
         step();
         k++;
      end
      if (n_wack < n) chk({name, "_timeout"}, 64'(n_wack), 64'(n));
   endtask

   initial begin
      clear_traces();
      do_reset();

      // minimum transaction from requester 0
      clear_traces();
      tick(); set_cmd(0, 32'h0000_1000, 8'd0, 4'd3); eval();
      run_until_wack(1, 30, "t1");
      chk("t1_ack_latency", 64'(t_ack - t_ready), 64'd4);
      chk("t1_rsp_valid", ack_rspv, 2'b01);
      chk("t1_beats", 64'(n_beats), 64'd1);
      chk("t1_wlast", 64'(n_wlast), 64'd1);

      // delayed awready, alternating wready, 4 beats from requester 1
      clear_traces();
      aw_delay = 5; w_mode = 1;
      tick(); set_cmd(1, 32'h0000_2040, 8'd3, 4'd9); eval();
      run_until_wack(1, 60, "t2");
      chk("t2_awvalid_cycles", 64'(n_awv), 64'd6);
      chk("t2_beats", 64'(n_beats), 64'd4);
      chk("t2_wlast_count", 64'(n_wlast), 64'd1);
      chk("t2_wlast_beat", 64'(wlast_at), 64'd4);
      chk("t2_rsp_valid", ack_rspv, 2'b10);

      // both requesters continuously valid: alternating grants
      do_reset();
      clear_traces();
      aw_delay = -1; aw_pct = 70; w_mode = 0; w_pct = 70; wv_pct = 80; b_pct = 70;
      bresp_force = -1; drop_on_grant = 0;
      tick(); set_cmd(0, 32'h0000_3000, 8'd1, 4'd1); set_cmd(1, 32'h0000_4000, 8'd2, 4'd2); eval();
      run_until_wack(4, 300, "t3");
      chk("t3_g0", (grants.size() > 0) ? 64'(grants[0]) : 64'd99, 64'd0);
      chk("t3_g1", (grants.size() > 1) ? 64'(grants[1]) : 64'd99, 64'd1);
      chk("t3_g2", (grants.size() > 2) ? 64'(grants[2]) : 64'd99, 64'd0);
      chk("t3_g3", (grants.size() > 3) ? 64'(grants[3]) : 64'd99, 64'd1);
      chk("t3_single_wready", 64'(n_bad_wr), 64'd0);

      // BID mismatch: sticky id_err, SLVERR still returned with wack
      drop_on_grant = 1;
      do_reset();
      clear_traces();
      aw_delay = 0; w_pct = 100; wv_pct = 100; b_pct = 100; bid_force = 5; bresp_force = 2;
      tick(); req_valid = '0; set_cmd(0, 32'h0000_5000, 8'd0, 4'd3); eval();
      run_until_wack(1, 30, "t4");
      chk("t4_rsp_resp", ack_resp, 2'b10);
      chk("t4_id_err", ack_ie, 1'b1);
      chk("t4_rsp_valid", ack_rspv, 2'b01);
      bid_force = -1; bresp_force = 0;
      tick(); set_cmd(1, 32'h0000_6000, 8'd1, 4'd7); eval();
      run_until_wack(2, 40, "t4b");
      step(); step();
      chk("t4_id_err_sticky", id_err, 1'b1);

      // reset during the second beat of an 8-beat burst
      do_reset();
      clear_traces();
      tick(); set_cmd(0, 32'h0000_7000, 8'd7, 4'd4); eval();
      for (int k = 0; k < 40 && n_beats < 1; k++) step();
      chk("t5_first_beat", 64'(n_beats), 64'd1);
      tick(); rst = 1'b1; eval();
      chk("t5_rst_wack", wack, 1'b0);
      chk("t5_rst_wvalid", wvalid, 1'b0);
      chk("t5_rst_awvalid", awvalid, 1'b0);
      chk("t5_rst_rsp_valid", rsp_valid, 2'b00);
      tick(); rst = 1'b0;
      set_cmd(0, 32'h0000_7100, 8'd0, 4'd4); set_cmd(1, 32'h0000_7200, 8'd0, 4'd5); eval();
      chk("t5_no_wack", 64'(n_wack), 64'd0);
      run_until_wack(1, 30, "t5");
      chk("t5_next_grant", (grants.size() > 0) ? 64'(grants[0]) : 64'd99, 64'd0);

      // longest burst: 256 beats, single wlast
      do_reset();
      clear_traces();
      w_pct = 85; wv_pct = 90;
      tick(); req_valid = '0; set_cmd(1, 32'h0000_8000, 8'd255, 4'd10); eval();
      run_until_wack(1, 900, "t6");
      chk("t6_beats", 64'(n_beats), 64'd256);
      chk("t6_wlast_count", 64'(n_wlast), 64'd1);
      chk("t6_wlast_beat", 64'(wlast_at), 64'd256);

      // random traffic, random slave, stray bvalid, occasional BID mismatch
      do_reset();
      clear_traces();
      rand_req = 1; aw_delay = -1; aw_pct = 60; w_pct = 70; wv_pct = 75; b_pct = 30;
      bid_force = -2; bresp_force = -1;
      for (int k = 0; k < 800; k++) step();
      chk("rand_progress", (n_wack >= 10) ? 64'd1 : 64'd0, 64'd1);
      chk("rand_single_wready", 64'(n_bad_wr), 64'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
